// File: rtl/uart_device.sv
// Full-duplex UART endpoint: a framed serializer on tx and an oversampling
// deserializer on rx. Each direction has its own three-process FSM.
module uart_device #(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 tx_busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;

  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // ---------------- transmitter ----------------
  state_t                 tx_state_r, tx_next_s;
  logic [CW-1:0]          tx_cnt_r;
  logic [2:0]             tx_bit_r;
  logic [DATA_BITS-1:0]   tx_shift_r, tx_shift_next_s;
  logic                   tx_par_r, tx_r, tx_ready_r, tx_busy_r;
  logic                   tx_s, tx_ready_s, tx_busy_s;
  logic                   tx_bit_end_s, tx_load_s;

  assign tx_bit_end_s = (tx_cnt_r == BIT_LAST);
  assign tx_load_s    = (tx_state_r == S_IDLE) && tx_valid;

  // TX state, baud counter, bit index and registered line outputs
  always_ff @(posedge pclk) begin
    if (areset) begin
      tx_state_r <= S_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_next_s;
      tx_shift_r <= tx_shift_next_s;
      tx_r       <= tx_s;
      tx_ready_r <= tx_ready_s;
      tx_busy_r  <= tx_busy_s;
      if (tx_load_s) tx_par_r <= parity_f(tx_data);
      if (tx_state_r == S_IDLE || tx_bit_end_s) tx_cnt_r <= '0;
      else tx_cnt_r <= tx_cnt_r + CNT_ONE;
      if (tx_next_s != tx_state_r) tx_bit_r <= 3'd0;
      else if (tx_bit_end_s) tx_bit_r <= tx_bit_r + 3'd1;
    end
  end

  // TX next-state
  always_comb begin
    tx_next_s = tx_state_r;
    case (tx_state_r)
      S_IDLE:   if (tx_valid) tx_next_s = S_START; else tx_next_s = S_IDLE;
      S_START:  if (tx_bit_end_s) tx_next_s = S_DATA; else tx_next_s = S_START;
      S_DATA:
        if (tx_bit_end_s && tx_bit_r == DATA_LAST) tx_next_s = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        else tx_next_s = S_DATA;
      S_PARITY: if (tx_bit_end_s) tx_next_s = S_STOP; else tx_next_s = S_PARITY;
      S_STOP:
        if (tx_bit_end_s && tx_bit_r == STOP_LAST) tx_next_s = S_IDLE;
        else tx_next_s = S_STOP;
      default:  tx_next_s = S_IDLE;
    endcase
  end

  // TX outputs are decoded from the next state so the line flops change with the state
  always_comb begin
    tx_shift_next_s = tx_shift_r;
    if (tx_load_s) tx_shift_next_s = tx_data;
    else if (tx_state_r == S_DATA && tx_bit_end_s) tx_shift_next_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
    else tx_shift_next_s = tx_shift_r;
    tx_s       = 1'b1;
    tx_ready_s = 1'b0;
    tx_busy_s  = 1'b1;
    case (tx_next_s)
      S_IDLE:   begin tx_s = 1'b1; tx_ready_s = 1'b1; tx_busy_s = 1'b0; end
      S_START:  tx_s = 1'b0;
      S_DATA:   tx_s = tx_shift_next_s[0];
      S_PARITY: tx_s = tx_par_r;
      S_STOP:   tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  assign tx       = tx_r;
  assign tx_ready = tx_ready_r;
  assign tx_busy  = tx_busy_r;

  // ---------------- receiver ----------------
  state_t                 rx_state_r, rx_next_s;
  logic                   rx_meta_r, rx_sync_r, rx_prev_r;
  logic [CW-1:0]          rx_cnt_r;
  logic [2:0]             rx_bit_r;
  logic [DATA_BITS-1:0]   rx_shift_r, rx_data_r;
  logic                   rx_par_bit_r, rx_valid_r, rx_perr_r, rx_ferr_r;
  logic                   rx_sample_s, rx_valid_s, rx_perr_s, rx_ferr_s;

  // Mid-bit sample point: half a bit into the start bit, then one full bit apart
  always_comb begin
    case (rx_state_r)
      S_START:                  rx_sample_s = (rx_cnt_r == HALF_LAST);
      S_DATA, S_PARITY, S_STOP: rx_sample_s = (rx_cnt_r == BIT_LAST);
      default:                  rx_sample_s = 1'b0;
    endcase
  end

  // RX synchronizer, state, counters and shift register
  always_ff @(posedge pclk) begin
    if (areset) begin
      rx_meta_r    <= 1'b1;
      rx_sync_r    <= 1'b1;
      rx_prev_r    <= 1'b1;
      rx_state_r   <= S_IDLE;
      rx_cnt_r     <= '0;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= '0;
      rx_par_bit_r <= 1'b0;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_next_s;
      if (rx_state_r == S_IDLE || rx_sample_s) rx_cnt_r <= '0;
      else rx_cnt_r <= rx_cnt_r + CNT_ONE;
      if (rx_next_s != rx_state_r) rx_bit_r <= 3'd0;
      else if (rx_sample_s) rx_bit_r <= rx_bit_r + 3'd1;
      if (rx_state_r == S_DATA && rx_sample_s) rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
      if (rx_state_r == S_PARITY && rx_sample_s) rx_par_bit_r <= rx_sync_r;
    end
  end

  // RX next-state; a start needs a falling edge, so a held-low line cannot re-arm
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      S_IDLE:   if (rx_prev_r && !rx_sync_r) rx_next_s = S_START; else rx_next_s = S_IDLE;
      S_START:
        if (rx_sample_s) rx_next_s = rx_sync_r ? S_IDLE : S_DATA;
        else rx_next_s = S_START;
      S_DATA:
        if (rx_sample_s && rx_bit_r == DATA_LAST) rx_next_s = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        else rx_next_s = S_DATA;
      S_PARITY: if (rx_sample_s) rx_next_s = S_STOP; else rx_next_s = S_PARITY;
      S_STOP:   if (rx_sample_s) rx_next_s = S_IDLE; else rx_next_s = S_STOP;
      default:  rx_next_s = S_IDLE;
    endcase
  end

  // RX result flags, evaluated at the stop-bit sample
  always_comb begin
    rx_valid_s = (rx_state_r == S_STOP) && rx_sample_s;
    rx_ferr_s  = !rx_sync_r;
    if (PARITY_EN != 0) rx_perr_s = (rx_par_bit_r != parity_f(rx_shift_r));
    else rx_perr_s = 1'b0;
  end

  // RX registered outputs, held until the next frame completes
  always_ff @(posedge pclk) begin
    if (areset) begin
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_valid_r <= rx_valid_s;
      if (rx_valid_s) begin
        rx_data_r <= rx_shift_r;
        rx_perr_r <= rx_perr_s;
        rx_ferr_r <= rx_ferr_s;
      end
    end
  end

  assign rx_valid      = rx_valid_r;
  assign rx_data       = rx_data_r;
  assign rx_parity_err = rx_perr_r;
  assign rx_frame_err  = rx_ferr_r;

endmodule

// File: tb/tb_uart_device.sv
// Directed bench for uart_device: dut0 is 8N1, dut1 is 8E1; each rx is either
// looped back from its own tx or driven bit by bit from the bench.
module tb_uart_device;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic       areset;
  logic [7:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic       tx_valid0, tx_valid1, tx_ready0, tx_ready1, tx0, tx1;
  logic       rx_valid0, rx_valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;
  logic       lb0, lb1, rx_drv0, rx_drv1, rx0, rx1;
  assign rx0 = lb0 ? tx0 : rx_drv0;
  assign rx1 = lb1 ? tx1 : rx_drv1;

  int checks = 0;
  int errors = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  logic [7:0] rxd0 [0:15];

  uart_device dut0 (
    .pclk(pclk), .areset(areset), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx(tx0), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .tx_busy(busy0));

  uart_device #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .pclk(pclk), .areset(areset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx(tx1), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .tx_busy(busy1));

  // count rx_valid pulses and log dut0 data in arrival order
  always @(negedge pclk) begin
    if (rx_valid0) begin
      if (cnt0 < 16) rxd0[cnt0] <= rx_data0;
      cnt0 <= cnt0 + 1;
    end
    if (rx_valid1) cnt1 <= cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present a byte and return once the handshake edge has passed; n = cycles waited
  task automatic xfer(input int which, input logic [7:0] d, output int n);
    n = 0;
    if (which == 0) begin tx_data0 = d; tx_valid0 = 1'b1; end
    else begin tx_data1 = d; tx_valid1 = 1'b1; end
    while (((which == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && n < 500) begin
      @(negedge pclk);
      n++;
    end
    chk("xfer_handshake", {31'd0, n < 500}, 32'd1);
    @(negedge pclk);
  endtask

  task automatic drive_bits(input int which, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (which == 0) rx_drv0 = bits[i]; else rx_drv1 = bits[i];
      repeat (16) @(negedge pclk);
    end
  endtask

  task automatic wait_cnt(input int which, input int target, input string tag);
    int n;
    n = 0;
    while (((which == 0) ? cnt0 : cnt1) < target && n < 600) begin
      @(negedge pclk);
      n++;
    end
    chk(tag, {31'd0, n < 600}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k, lows;
    logic [15:0] fr;
    areset = 1'b1; tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_data0 = 8'h00; tx_data1 = 8'h00;
    lb0 = 1'b1; lb1 = 1'b1; rx_drv0 = 1'b1; rx_drv1 = 1'b1;
    repeat (3) @(negedge pclk);
    areset = 1'b0;
    @(negedge pclk);
    chk("rst_tx", tx0, 1); chk("rst_ready", tx_ready0, 1); chk("rst_busy", busy0, 0);
    chk("rst_rxv", rx_valid0, 0); chk("rst_rxd", rx_data0, 0);
    chk("rst_perr", perr0, 0); chk("rst_ferr", ferr0, 0); chk("rst_tx1", tx1, 1);
    repeat (50) @(negedge pclk);
    chk("idle_tx", tx0, 1); chk("idle_ready", tx_ready0, 1);
    chk("idle_no_rxv0", cnt0, 0); chk("idle_no_rxv1", cnt1, 0);

    // loopback 0xA5: start bit occupies cycles 1..16, then bit0 = 1
    xfer(0, 8'hA5, n);
    tx_valid0 = 1'b0;
    chk("a5_ready_low", tx_ready0, 0); chk("a5_busy", busy0, 1);
    lows = 0;
    for (int i = 1; i <= 16; i++) begin
      if (tx0 === 1'b0) lows++;
      @(negedge pclk);
    end
    chk("a5_start_len", lows, 16); chk("a5_bit0", tx0, 1);
    k = 17;
    while (rx_valid0 !== 1'b1 && k < 300) begin
      @(negedge pclk);
      k++;
    end
    chk("a5_latency", {31'd0, (k >= 150 && k <= 165)}, 32'd1);
    chk("a5_data", rx_data0, 8'hA5); chk("a5_perr", perr0, 0); chk("a5_ferr", ferr0, 0);
    @(negedge pclk);
    chk("a5_pulse_1cyc", rx_valid0, 0);
    repeat (20) @(negedge pclk);
    chk("a5_pulse_count", cnt0, 1);

    // back-to-back with tx_valid held: next accept exactly 160 cycles after the last
    xfer(0, 8'h00, n);
    xfer(0, 8'hFF, n); chk("b2b_gap_ff", n, 160);
    xfer(0, 8'h3C, n); chk("b2b_gap_3c", n, 160);
    tx_valid0 = 1'b0;
    wait_cnt(0, 4, "b2b_rx_timeout");
    repeat (2) @(negedge pclk);
    chk("b2b_d0", rxd0[1], 8'h00); chk("b2b_d1", rxd0[2], 8'hFF); chk("b2b_d2", rxd0[3], 8'h3C);

    // even parity on 0x07: data bit7 = 0 (cycles 129..144), parity = 1 (cycles 145..160)
    xfer(1, 8'h07, n);
    tx_valid1 = 1'b0;
    repeat (134) @(negedge pclk);
    chk("par_bit7", tx1, 0);
    repeat (15) @(negedge pclk);
    chk("par_bit", tx1, 1);
    wait_cnt(1, 1, "par_rx_timeout");
    repeat (2) @(negedge pclk);
    chk("par_data", rx_data1, 8'h07); chk("par_perr", perr1, 0); chk("par_ferr", ferr1, 0);

    // corrupted parity bit (0 instead of 1)
    repeat (30) @(negedge pclk);
    lb1 = 1'b0;
    repeat (5) @(negedge pclk);
    fr = {5'd0, 1'b1, 1'b0, 8'h07, 1'b0};
    drive_bits(1, fr, 11);
    repeat (10) @(negedge pclk);
    chk("bad_par_count", cnt1, 2); chk("bad_par_data", rx_data1, 8'h07);
    chk("bad_par_perr", perr1, 1); chk("bad_par_ferr", ferr1, 0);

    // 0x55 with a low stop bit, line held low a further bit, then released
    lb0 = 1'b0;
    repeat (5) @(negedge pclk);
    fr = {6'd0, 1'b0, 8'h55, 1'b0};
    drive_bits(0, fr, 10);
    repeat (16) @(negedge pclk);
    rx_drv0 = 1'b1;
    repeat (40) @(negedge pclk);
    chk("ferr_count", cnt0, 5); chk("ferr_data", rx_data0, 8'h55);
    chk("ferr_flag", ferr0, 1); chk("ferr_perr", perr0, 0);

    // 4-cycle glitch is a false start
    rx_drv0 = 1'b0;
    repeat (4) @(negedge pclk);
    rx_drv0 = 1'b1;
    repeat (200) @(negedge pclk);
    chk("glitch_no_rxv", cnt0, 5);

    // reset during data bit 3 (cycles 65..80) of 0x5A
    lb0 = 1'b1;
    repeat (5) @(negedge pclk);
    xfer(0, 8'h5A, n);
    tx_valid0 = 1'b0;
    repeat (69) @(negedge pclk);
    chk("mid_busy", busy0, 1);
    areset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_tx", tx0, 1); chk("mid_rst_ready", tx_ready0, 1); chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_rxd", rx_data0, 0); chk("mid_rst_ferr", ferr0, 0);
    areset = 1'b0;
    repeat (300) @(negedge pclk);
    chk("mid_rst_no_rxv", cnt0, 5);
    xfer(0, 8'hC3, n);
    tx_valid0 = 1'b0;
    wait_cnt(0, 6, "post_rst_timeout");
    repeat (2) @(negedge pclk);
    chk("post_rst_data", rx_data0, 8'hC3); chk("post_rst_perr", perr0, 0);
    chk("post_rst_ferr", ferr0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
